tx_bus_scheduler: RTL

Frame scheduler and half-duplex bus owner in front of the UART byte transmitter in the comms path.
- Periodically sends one telemetry frame per status channel (position, velocity, displacement, current), round-robin.
- Sends an on-demand setpoint response frame, which has priority over telemetry.
- Drives the RS485 driver enable with pre/post guard times.
- Sits between the motor status registers and the UART TX shifter.

---
 rtl/tx_sched_pkg.sv | 28 ++
 rtl/tx_sched_chk.sv | 24 ++
 rtl/tx_bus_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tx_sched_pkg.sv
// rtl/tx_sched_pkg.sv - frame constants, FSM encoding and CRC-8 step for the TX bus scheduler
package tx_sched_pkg;

  localparam logic [7:0] HDR_TEL   = 8'hAA;
  localparam logic [7:0] HDR_RESP  = 8'h55;
  localparam logic [7:0] ID_RESP   = 8'h04;
  localparam int         FRAME_LEN = 7;
  localparam logic [7:0] CRC_POLY  = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SEND,
    ST_DRAIN,
    ST_POST
  } sched_state_t;

  // One byte of CRC-8, MSB first, no reflection.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/tx_sched_chk.sv
// rtl/tx_sched_chk.sv - byte-serial frame checksum accumulator (XOR, or CRC-8 when TX_SCHED_CRC8_EN is defined)
module tx_sched_chk (
  input  logic       CLK,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] chk
);
  import tx_sched_pkg::*;

  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      chk <= 8'h00;
    end else if (enable) begin
`ifdef TX_SCHED_CRC8_EN
      chk <= crc8_update(chk, data);
`else
      chk <= chk ^ data;
`endif
    end
  end

endmodule

// File: rtl/tx_bus_scheduler.sv
// rtl/tx_bus_scheduler.sv - telemetry/response frame scheduler and RS485 bus owner in front of the UART TX
// Checksum flavour follows TX_SCHED_CRC8_EN (CRC-8 when defined, XOR otherwise).
module tx_bus_scheduler #(
  parameter int PERIOD_CYCLES = 16000,
  parameter int GUARD_CYCLES  = 16,
  parameter int WORD_W        = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [WORD_W-1:0] position,
  input  logic [WORD_W-1:0] velocity,
  input  logic [WORD_W-1:0] displacement,
  input  logic [WORD_W-1:0] current,
  input  logic [WORD_W-1:0] setpoint,
  input  logic              resp_req,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              tx_busy,
  output logic              tx_enable,
  output logic              frame_done,
  output logic [7:0]        overrun_cnt
);
  import tx_sched_pkg::*;

  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  sched_state_t      state, state_nxt;
  logic [PW-1:0]     per_cnt;
  logic [GW-1:0]     guard_cnt;
  logic [2:0]        idx;
  logic [1:0]        ch_ptr;
  logic              tel_pend, resp_pend, is_resp;
  logic [WORD_W-1:0] word_q, ch_word;
  logic [7:0]        chk, frame_byte;
  logic              tick, sel_resp, sel_tel, in_guard, guard_done, hs, last_hs;

  assign tick       = (per_cnt == PW'(PERIOD_CYCLES - 1));
  assign sel_resp   = (state == ST_IDLE) && resp_pend;
  assign sel_tel    = (state == ST_IDLE) && !resp_pend && tel_pend;
  assign in_guard   = (state == ST_PRE) || (state == ST_POST);
  assign guard_done = (guard_cnt == GW'(GUARD_CYCLES - 1));
  assign hs         = (state == ST_SEND) && tx_ready;
  assign last_hs    = hs && (idx == 3'(FRAME_LEN - 1));

  always_comb begin
    case (ch_ptr)
      2'd0: ch_word = position;
      2'd1: ch_word = velocity;
      2'd2: ch_word = displacement;
      2'd3: ch_word = current;
    endcase
  end

  always_comb begin
    frame_byte = 8'h00;
    case (idx)
      3'd0:    frame_byte = is_resp ? HDR_RESP : HDR_TEL;
      3'd1:    frame_byte = is_resp ? ID_RESP : {6'd0, ch_ptr};
      3'd2:    frame_byte = word_q[31:24];
      3'd3:    frame_byte = word_q[23:16];
      3'd4:    frame_byte = word_q[15:8];
      3'd5:    frame_byte = word_q[7:0];
      3'd6:    frame_byte = chk;
      default: frame_byte = 8'h00;
    endcase
  end

  // id and data bytes feed the checksum as they are accepted; header and chk do not.
  tx_sched_chk u_chk (
    .CLK    (CLK),
    .reset  (reset),
    .clear  (sel_resp || sel_tel),
    .enable (hs && (idx >= 3'd1) && (idx <= 3'd5)),
    .data   (frame_byte),
    .chk    (chk)
  );

  always_ff @(posedge CLK) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (sel_resp || sel_tel) state_nxt = ST_PRE;
      ST_PRE:   if (guard_done) state_nxt = ST_SEND;
      ST_SEND:  if (last_hs) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!tx_busy) state_nxt = ST_POST;
      ST_POST:  if (guard_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      per_cnt     <= '0;
      guard_cnt   <= '0;
      idx         <= 3'd0;
      ch_ptr      <= 2'd0;
      tel_pend    <= 1'b0;
      resp_pend   <= 1'b0;
      is_resp     <= 1'b0;
      word_q      <= '0;
      frame_done  <= 1'b0;
      overrun_cnt <= 8'h00;
    end else begin
      per_cnt   <= tick ? '0 : per_cnt + 1'b1;
      // A new tick wins over a same-cycle clear so it is never lost.
      tel_pend  <= tick || (tel_pend && !sel_tel);
      resp_pend <= resp_req || (resp_pend && !sel_resp);
      if (tick && tel_pend && !sel_tel && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;
      if (sel_resp || sel_tel) begin
        word_q  <= sel_resp ? setpoint : ch_word;
        is_resp <= sel_resp;
      end
      guard_cnt <= (in_guard && !guard_done) ? guard_cnt + 1'b1 : '0;
      if (hs) idx <= last_hs ? 3'd0 : idx + 3'd1;
      frame_done <= (state == ST_POST) && guard_done;
      if ((state == ST_POST) && guard_done && !is_resp)
        ch_ptr <= ch_ptr + 2'd1;
    end
  end

  assign tx_valid  = (state == ST_SEND);
  assign tx_byte   = tx_valid ? frame_byte : 8'h00;
  assign tx_enable = (state != ST_IDLE);

endmodule
